// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
// Holds the mode encoding and the counter-width helper.
package usr_pkg;

  typedef enum logic [2:0] {
    M_HOLD     = 3'b000,
    M_SHIFT_UP = 3'b001,
    M_SHIFT_DN = 3'b010,
    M_ROT_UP   = 3'b011,
    M_ROT_DN   = 3'b100,
    M_LOAD     = 3'b101,
    M_CLEAR    = 3'b110,
    M_RSVD     = 3'b111
  } shift_mode_t;

  // Bits needed to hold a count of 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_ctr.sv
// Shift counter and word_ready strobe for serial framing.
// Ports: clk, rst (sync, high), step, restart, cnt, word_ready.
module usr_ctr
  import usr_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step,
  input  logic                      restart,
  output logic [cnt_w(WIDTH)-1:0]   cnt,
  output logic                      word_ready
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      word_ready <= 1'b0;
    end else if (step) begin
      // The WIDTH-th operation wraps and flags a full word.
      if (cnt == LAST) begin
        cnt        <= '0;
        word_ready <= 1'b1;
      end else begin
        cnt        <= cnt + ONE;
        word_ready <= 1'b0;
      end
    end else begin
      if (restart) cnt <= '0;
      word_ready <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: shift/rotate both ways, load, clear.
// Ports: clk, rst, en, mode, ser_in_up/dn, par_in, q, ser_out_up/dn, shift_cnt, word_ready.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic                     ser_in_up,
  input  logic                     ser_in_dn,
  input  logic [WIDTH-1:0]         par_in,
  output logic [WIDTH-1:0]         q,
  output logic                     ser_out_up,
  output logic                     ser_out_dn,
  output logic [cnt_w(WIDTH)-1:0]  shift_cnt,
  output logic                     word_ready
);

  shift_mode_t m;
  logic        step;
  logic        restart;

  assign m = shift_mode_t'(mode);

  assign step    = en && (m inside {M_SHIFT_UP, M_SHIFT_DN,
                                    M_ROT_UP, M_ROT_DN});
  assign restart = en && (m inside {M_LOAD, M_CLEAR});

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      unique case (m)
        M_SHIFT_UP: q <= {q[WIDTH-2:0], ser_in_up};
        M_SHIFT_DN: q <= {ser_in_dn, q[WIDTH-1:1]};
        M_ROT_UP:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
        M_ROT_DN:   q <= {q[0], q[WIDTH-1:1]};
        M_LOAD:     q <= par_in;
        M_CLEAR:    q <= '0;
        default:    q <= q;
      endcase
    end
  end

  assign ser_out_up = q[WIDTH-1];
  assign ser_out_dn = q[0];

  usr_ctr #(
    .WIDTH(WIDTH)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .restart   (restart),
    .cnt       (shift_cnt),
    .word_ready(word_ready)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register at WIDTH 6, 2 and 16.
// Table vectors, corner sequences, and random stimulus vs a model.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic        su;
  logic        sd;
  logic [15:0] par;

  logic [5:0]  q6;
  logic        sou6, sod6, wr6;
  logic [2:0]  c6;
  logic [1:0]  q2;
  logic        sou2, sod2, wr2;
  logic [1:0]  c2;
  logic [15:0] q16;
  logic        sou16, sod16, wr16;
  logic [4:0]  c16;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(6)) u6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .ser_in_up(su), .ser_in_dn(sd), .par_in(par[5:0]),
    .q(q6), .ser_out_up(sou6), .ser_out_dn(sod6),
    .shift_cnt(c6), .word_ready(wr6)
  );

  universal_shift_register #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .ser_in_up(su), .ser_in_dn(sd), .par_in(par[1:0]),
    .q(q2), .ser_out_up(sou2), .ser_out_dn(sod2),
    .shift_cnt(c2), .word_ready(wr2)
  );

  universal_shift_register #(
    .WIDTH(16), .RESET_VALUE(16'hA5A5)
  ) u16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .ser_in_up(su), .ser_in_dn(sd), .par_in(par),
    .q(q16), .ser_out_up(sou16), .ser_out_dn(sod16),
    .shift_cnt(c16), .word_ready(wr16)
  );

  // Behavioural model: word as an integer, count of operations.
  int       wd [3] = '{6, 2, 16};
  int       rv [3] = '{0, 0, 16'hA5A5};
  int       mq [3];
  int       mc [3];
  int       mw [3];

  task automatic model_step(input int d);
    int w;
    int mask;
    bit counted;
    w = wd[d];
    mask = (1 << w) - 1;
    counted = 1'b0;
    if (rst) begin
      mq[d] = rv[d];
      mc[d] = 0;
      mw[d] = 0;
    end else if (!en) begin
      mw[d] = 0;
    end else begin
      case (mode)
        3'd1: begin
          mq[d] = ((mq[d] << 1) | int'(su)) & mask;
          counted = 1'b1;
        end
        3'd2: begin
          mq[d] = (mq[d] >> 1) | (int'(sd) << (w - 1));
          counted = 1'b1;
        end
        3'd3: begin
          mq[d] = ((mq[d] << 1) | ((mq[d] >> (w - 1)) & 1)) & mask;
          counted = 1'b1;
        end
        3'd4: begin
          mq[d] = (mq[d] >> 1) | ((mq[d] & 1) << (w - 1));
          counted = 1'b1;
        end
        3'd5: begin
          mq[d] = int'(par) & mask;
          mc[d] = 0;
          mw[d] = 0;
        end
        3'd6: begin
          mq[d] = 0;
          mc[d] = 0;
          mw[d] = 0;
        end
        default: mw[d] = 0;
      endcase
      if (counted) begin
        mc[d] = mc[d] + 1;
        if (mc[d] == w) begin
          mc[d] = 0;
          mw[d] = 1;
        end else begin
          mw[d] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  task automatic check_models();
    chk("w6.q",   int'(q6),    mq[0]);
    chk("w6.cnt", int'(c6),    mc[0]);
    chk("w6.wr",  int'(wr6),   mw[0]);
    chk("w6.sou", int'(sou6),  (mq[0] >> 5) & 1);
    chk("w6.sod", int'(sod6),  mq[0] & 1);
    chk("w2.q",   int'(q2),    mq[1]);
    chk("w2.cnt", int'(c2),    mc[1]);
    chk("w2.wr",  int'(wr2),   mw[1]);
    chk("w2.sou", int'(sou2),  (mq[1] >> 1) & 1);
    chk("w2.sod", int'(sod2),  mq[1] & 1);
    chk("w16.q",  int'(q16),   mq[2]);
    chk("w16.cnt", int'(c16),  mc[2]);
    chk("w16.wr", int'(wr16),  mw[2]);
    chk("w16.sou", int'(sou16), (mq[2] >> 15) & 1);
    chk("w16.sod", int'(sod16), mq[2] & 1);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    check_models();
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    shift_mode_t mode;
    logic        su;
    logic        sd;
    logic [5:0]  par;
    logic [5:0]  eq;
    logic [2:0]  ec;
    logic        ew;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic e, input shift_mode_t md,
    input logic u, input logic dn, input logic [5:0] p,
    input logic [5:0] xq, input logic [2:0] xc, input logic xw);
    vec_t v;
    v.rst = r; v.en = e; v.mode = md; v.su = u; v.sd = dn;
    v.par = p; v.eq = xq; v.ec = xc; v.ew = xw;
    return v;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0;
    su = 1'b0; sd = 1'b0; par = '0;
    for (int d = 0; d < 3; d++) begin
      mq[d] = 0; mc[d] = 0; mw[d] = 0;
    end

    // reset beats LOAD, then LOAD
    tbl.push_back(mk(1,1,M_LOAD,0,0,6'b111111, 6'b000000,0,0));
    tbl.push_back(mk(0,1,M_LOAD,0,0,6'b101100, 6'b101100,0,0));
    // serial framing 1,0,1,1,0,1
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b011001,1,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,0,0,0, 6'b110010,2,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b100101,3,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b001011,4,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,0,0,0, 6'b010110,5,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b101101,0,1));
    tbl.push_back(mk(0,1,M_HOLD,0,0,0,     6'b101101,0,0));
    // rotate a single one around
    tbl.push_back(mk(0,1,M_LOAD,0,0,6'b000001, 6'b000001,0,0));
    tbl.push_back(mk(0,1,M_ROT_UP,0,0,0, 6'b000010,1,0));
    tbl.push_back(mk(0,1,M_ROT_UP,0,0,0, 6'b000100,2,0));
    tbl.push_back(mk(0,1,M_ROT_UP,0,0,0, 6'b001000,3,0));
    tbl.push_back(mk(0,1,M_ROT_UP,0,0,0, 6'b010000,4,0));
    tbl.push_back(mk(0,1,M_ROT_UP,0,0,0, 6'b100000,5,0));
    tbl.push_back(mk(0,1,M_ROT_UP,0,0,0, 6'b000001,0,1));
    tbl.push_back(mk(0,1,M_SHIFT_DN,0,1,0, 6'b100000,1,0));
    // enable gating mid-word
    tbl.push_back(mk(0,1,M_LOAD,0,0,6'b000000, 6'b000000,0,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b000001,1,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b000011,2,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b000111,3,0));
    tbl.push_back(mk(0,0,M_LOAD,1,1,6'b110110, 6'b000111,3,0));
    tbl.push_back(mk(0,0,M_CLEAR,1,1,0,  6'b000111,3,0));
    tbl.push_back(mk(0,0,M_ROT_UP,1,1,0, 6'b000111,3,0));
    tbl.push_back(mk(0,0,M_SHIFT_UP,1,1,0, 6'b000111,3,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,0,0,0, 6'b001110,4,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,0,0,0, 6'b011100,5,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,0,0,0, 6'b111000,0,1));
    // clear restarts framing without a strobe
    tbl.push_back(mk(0,1,M_SHIFT_DN,0,1,0, 6'b111100,1,0));
    tbl.push_back(mk(0,1,M_SHIFT_DN,0,1,0, 6'b111110,2,0));
    tbl.push_back(mk(0,1,M_SHIFT_DN,0,1,0, 6'b111111,3,0));
    tbl.push_back(mk(0,1,M_SHIFT_DN,0,1,0, 6'b111111,4,0));
    tbl.push_back(mk(0,1,M_CLEAR,0,0,0,    6'b000000,0,0));
    // reset priority, reserved mode holds
    tbl.push_back(mk(0,1,M_LOAD,0,0,6'b010101, 6'b010101,0,0));
    tbl.push_back(mk(1,1,M_LOAD,0,0,6'b101010, 6'b000000,0,0));
    tbl.push_back(mk(0,1,M_LOAD,0,0,6'b110011, 6'b110011,0,0));
    tbl.push_back(mk(0,1,M_RSVD,1,1,6'b001100, 6'b110011,0,0));
    tbl.push_back(mk(0,1,M_SHIFT_UP,1,0,0, 6'b100111,1,0));
    tbl.push_back(mk(0,1,M_RSVD,1,1,0,     6'b100111,1,0));
    tbl.push_back(mk(0,1,M_ROT_DN,0,0,0,   6'b110011,2,0));

    foreach (tbl[i]) begin
      rst  = tbl[i].rst;
      en   = tbl[i].en;
      mode = tbl[i].mode;
      su   = tbl[i].su;
      sd   = tbl[i].sd;
      par  = {10'h155, tbl[i].par};
      tick();
      chk($sformatf("tbl%0d.q", i),   int'(q6),  int'(tbl[i].eq));
      chk($sformatf("tbl%0d.cnt", i), int'(c6),  int'(tbl[i].ec));
      chk($sformatf("tbl%0d.wr", i),  int'(wr6), int'(tbl[i].ew));
    end

    // reset value on the wide instance, strobe spacing on 2 and 16
    rst = 1'b1; en = 1'b1; mode = M_SHIFT_UP; su = 1'b1;
    tick();
    chk("w16.rstval", int'(q16), 16'hA5A5);
    chk("w2.rstval",  int'(q2),  0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("w2.strobe%0d", k),  int'(wr2),  int'(k % 2 == 0));
      chk($sformatf("w16.strobe%0d", k), int'(wr16), int'(k == 16));
    end

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 99) < 2);
      en   = ($urandom_range(0, 99) < 80);
      mode = 3'($urandom_range(0, 7));
      su   = 1'($urandom);
      sd   = 1'($urandom);
      par  = 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
